// File: rtl/core_pkg.sv
// Shared types for the core memory arbiter: FSM states, requester identity and
// the grant-vector bit positions used by the round-robin picker.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2
   } mem_arb_state_t;

   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_DATA  = 1'b1
   } mem_owner_t;

   // Bit positions inside the 2-bit request and grant vectors.
   localparam int GNT_FETCH = 0;
   localparam int GNT_DATA  = 1;

   function automatic mem_owner_t owner_of(input logic [1:0] gnt);
      return gnt[GNT_DATA] ? OWNER_DATA : OWNER_FETCH;
   endfunction

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundle of the fetch port, the data port, the fetch-invalidate control and the
// shared memory bus. The slave modport is the arbiter's view; master is its environment.
interface core_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_req_addr;
   logic              if_rsp_valid;
   logic [DATA_W-1:0] if_rsp_data;

   logic              d_req_valid;
   logic              d_req_ready;
   logic [ADDR_W-1:0] d_req_addr;
   logic              d_req_we;
   logic [DATA_W-1:0] d_req_wdata;
   logic [STRB_W-1:0] d_req_wstrb;
   logic              d_rsp_valid;
   logic [DATA_W-1:0] d_rsp_rdata;

   logic              invalidate_fetch;

   logic              bus_req_valid;
   logic              bus_req_ready;
   logic [ADDR_W-1:0] bus_req_addr;
   logic              bus_req_we;
   logic [DATA_W-1:0] bus_req_wdata;
   logic [STRB_W-1:0] bus_req_wstrb;
   logic              bus_rsp_valid;
   logic [DATA_W-1:0] bus_rsp_data;

   modport slave (
      input  if_req_valid, if_req_addr,
      output if_req_ready, if_rsp_valid, if_rsp_data,
      input  d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
      output d_req_ready, d_rsp_valid, d_rsp_rdata,
      input  invalidate_fetch,
      output bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_wstrb,
      input  bus_req_ready, bus_rsp_valid, bus_rsp_data
   );

   modport master (
      output if_req_valid, if_req_addr,
      input  if_req_ready, if_rsp_valid, if_rsp_data,
      output d_req_valid, d_req_addr, d_req_we, d_req_wdata, d_req_wstrb,
      input  d_req_ready, d_rsp_valid, d_rsp_rdata,
      output invalidate_fetch,
      input  bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_wstrb,
      output bus_req_ready, bus_rsp_valid, bus_rsp_data
   );

endinterface

// File: rtl/core_rr_pick2.sv
// Two-way round-robin picker: on a conflict the side that did not win last time
// is granted. Purely combinational, one-hot (or zero) grant.
module core_rr_pick2
   import core_pkg::*;
(
   input  logic [1:0] req_i,
   input  mem_owner_t last_grant_i,
   output logic [1:0] gnt_o
);

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_grant_i == OWNER_FETCH) ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/core_mem_arbiter.sv
// Arbitrates the fetch and data ports onto one memory bus with a single
// outstanding transaction; fetches can be discarded in flight by invalidate_fetch.
module core_mem_arbiter
   import core_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic               clk,
   input logic               rst,
   core_mem_arbiter_if.slave bus_if
);

   localparam int STRB_W = DATA_W / 8;

   mem_arb_state_t    state_q;
   mem_owner_t        last_grant_q;   // also the owner of the transaction in flight
   logic              drop_q;
   logic              if_rsp_valid_q;
   logic              d_rsp_valid_q;

   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [DATA_W-1:0] wdata_q;
   logic [STRB_W-1:0] wstrb_q;
   logic [DATA_W-1:0] rdata_q;

   logic              in_idle;
   logic              fetch_inv;
   logic [1:0]        req_vec;
   logic [1:0]        gnt_vec;

   // NOTE: ready must answer valid in the same cycle, so the grant is combinational
   // from registered state; it is forced low while rst is held.
   always_comb begin
      in_idle                = (state_q == IDLE) && !rst;
      req_vec                = 2'b00;
      req_vec[GNT_FETCH]     = in_idle && bus_if.if_req_valid && !bus_if.invalidate_fetch;
      req_vec[GNT_DATA]      = in_idle && bus_if.d_req_valid;
      fetch_inv              = bus_if.invalidate_fetch && (last_grant_q == OWNER_FETCH);
   end

   core_rr_pick2 u_pick (
      .req_i        (req_vec),
      .last_grant_i (last_grant_q),
      .gnt_o        (gnt_vec)
   );

   assign bus_if.if_req_ready  = gnt_vec[GNT_FETCH];
   assign bus_if.d_req_ready   = gnt_vec[GNT_DATA];

   assign bus_if.bus_req_valid = (state_q == REQ);
   assign bus_if.bus_req_addr  = addr_q;
   assign bus_if.bus_req_we    = we_q;
   assign bus_if.bus_req_wdata = wdata_q;
   assign bus_if.bus_req_wstrb = wstrb_q;

   assign bus_if.if_rsp_valid  = if_rsp_valid_q;
   assign bus_if.if_rsp_data   = rdata_q;
   assign bus_if.d_rsp_valid   = d_rsp_valid_q;
   assign bus_if.d_rsp_rdata   = rdata_q;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         last_grant_q   <= OWNER_FETCH;
         drop_q         <= 1'b0;
         if_rsp_valid_q <= 1'b0;
         d_rsp_valid_q  <= 1'b0;
      end else begin
         if_rsp_valid_q <= 1'b0;
         d_rsp_valid_q  <= 1'b0;
         unique case (state_q)
            IDLE: begin
               drop_q <= 1'b0;
               if (|gnt_vec) begin
                  state_q      <= REQ;
                  last_grant_q <= owner_of(gnt_vec);
               end
            end
            REQ: begin
               if (fetch_inv) drop_q <= 1'b1;
               if (bus_if.bus_req_ready) state_q <= WAIT_RSP;
            end
            WAIT_RSP: begin
               if (bus_if.bus_rsp_valid) begin
                  state_q <= IDLE;
                  drop_q  <= 1'b0;
                  // A dropped fetch still drains the bus but never reaches the core.
                  if (last_grant_q == OWNER_DATA) d_rsp_valid_q <= 1'b1;
                  else if_rsp_valid_q <= !(drop_q || bus_if.invalidate_fetch);
               end else if (fetch_inv) begin
                  drop_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: request fields and response data carry no reset; they are only
   // observed behind a valid that is itself reset.
   always_ff @(posedge clk) begin
      if (|gnt_vec) begin
         if (gnt_vec[GNT_DATA]) begin
            addr_q  <= bus_if.d_req_addr;
            we_q    <= bus_if.d_req_we;
            wdata_q <= bus_if.d_req_wdata;
            wstrb_q <= bus_if.d_req_wstrb;
         end else begin
            addr_q  <= bus_if.if_req_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
         end
      end
      if ((state_q == WAIT_RSP) && bus_if.bus_rsp_valid) rdata_q <= bus_if.bus_rsp_data;
   end

   a_ready_excl : assert property (@(posedge clk) disable iff (rst)
      !(bus_if.if_req_ready && bus_if.d_req_ready));
   a_ready_idle : assert property (@(posedge clk) disable iff (rst)
      (bus_if.if_req_ready || bus_if.d_req_ready) |-> (state_q == IDLE));
   a_rsp_excl   : assert property (@(posedge clk) disable iff (rst)
      !(if_rsp_valid_q && d_rsp_valid_q));

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: directed requests push expected responses,
// a bus model answers the arbiter, and a monitor pops and compares every response pulse.
module tb_core_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef struct {
      bit          is_data;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   core_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

   core_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bif)
   );

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          accept_cyc = 0;
   int          rsp_cyc = 0;

   logic [31:0] mem [logic [31:0]];
   int          stall_n = 0;
   int          rsp_wait = 0;
   bit          model_on = 1'b1;
   logic [31:0] cap_addr, cap_wdata, first_addr, first_wdata;
   logic        cap_we, first_we;
   logic [3:0]  cap_wstrb, first_wstrb;

   initial forever @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input bit is_data, input logic [31:0] data);
      exp_t e;
      e.is_data = is_data;
      e.data    = data;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input bit is_data, input logic [31:0] data);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL unexpected_rsp: %s pulsed with 0x%0h, expected no response (t=%0t)",
                  is_data ? "d_rsp" : "if_rsp", data, $time);
      end else begin
         e = sb_q.pop_front();
         check("rsp_side", 32'(is_data), 32'(e.is_data));
         check("rsp_data", data, e.data);
         rsp_cyc = cyc;
      end
   endtask

   // Monitor: every response pulse must match the head of the scoreboard.
   initial forever begin
      @(negedge clk);
      if (bif.if_rsp_valid === 1'b1) sb_pop(1'b0, bif.if_rsp_data);
      if (bif.d_rsp_valid === 1'b1)  sb_pop(1'b1, bif.d_rsp_rdata);
   end

   // Bus model: optional request stall, then a response after rsp_wait extra cycles.
   initial begin
      int phase = 0;
      int cnt   = 0;
      bif.bus_req_ready = 1'b0;
      bif.bus_rsp_valid = 1'b0;
      bif.bus_rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bif.bus_req_ready = 1'b0;
            bif.bus_rsp_valid = 1'b0;
            phase = 0;
            cnt   = 0;
         end else if (model_on) begin
            bif.bus_rsp_valid = 1'b0;
            if (phase == 0) begin
               bif.bus_req_ready = 1'b0;
               if (bif.bus_req_valid) begin
                  if (cnt == 0) begin
                     first_addr  = bif.bus_req_addr;
                     first_we    = bif.bus_req_we;
                     first_wdata = bif.bus_req_wdata;
                     first_wstrb = bif.bus_req_wstrb;
                  end else begin
                     check("stall_addr",  bif.bus_req_addr, first_addr);
                     check("stall_we",    32'(bif.bus_req_we), 32'(first_we));
                     check("stall_wdata", bif.bus_req_wdata, first_wdata);
                     check("stall_wstrb", 32'(bif.bus_req_wstrb), 32'(first_wstrb));
                  end
                  if (cnt < stall_n) begin
                     cnt++;
                  end else begin
                     bif.bus_req_ready = 1'b1;
                     cap_addr  = bif.bus_req_addr;
                     cap_we    = bif.bus_req_we;
                     cap_wdata = bif.bus_req_wdata;
                     cap_wstrb = bif.bus_req_wstrb;
                     phase = 1;
                     cnt   = 0;
                  end
               end
            end else begin
               bif.bus_req_ready = 1'b0;
               if (cnt < rsp_wait) begin
                  cnt++;
               end else begin
                  bif.bus_rsp_valid = 1'b1;
                  if (cap_we) begin
                     mem[cap_addr]    = cap_wdata;
                     bif.bus_rsp_data = 32'h0;
                  end else begin
                     bif.bus_rsp_data = mem.exists(cap_addr) ? mem[cap_addr] : 32'h0;
                  end
                  phase = 0;
                  cnt   = 0;
               end
            end
         end
      end
   end

   // Called at a falling edge with valid already driven; returns just after the accepting edge.
   task automatic wait_grant(input bit is_data, output bit got);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (is_data ? bif.d_req_ready : bif.if_req_ready) begin
            got = 1'b1;
            accept_cyc = cyc;
         end
         @(posedge clk);
         if (got) break;
         @(negedge clk);
      end
      check(is_data ? "d_grant" : "if_grant", 32'(got), 32'd1);
   endtask

   task automatic do_req(input bit is_data, input logic [31:0] addr, input bit we,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
      bit got;
      @(negedge clk);
      if (is_data) begin
         bif.d_req_valid = 1'b1;
         bif.d_req_addr  = addr;
         bif.d_req_we    = we;
         bif.d_req_wdata = wdata;
         bif.d_req_wstrb = wstrb;
      end else begin
         bif.if_req_valid = 1'b1;
         bif.if_req_addr  = addr;
      end
      wait_grant(is_data, got);
      @(negedge clk);
      if (is_data) bif.d_req_valid = 1'b0;
      else bif.if_req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_if_rsp"}, 32'(bif.if_rsp_valid), 32'd0);
      check({tag, "_d_rsp"},  32'(bif.d_rsp_valid),  32'd0);
      check({tag, "_bus_vld"}, 32'(bif.bus_req_valid), 32'd0);
      check({tag, "_if_rdy"}, 32'(bif.if_req_ready), 32'd0);
      check({tag, "_d_rdy"},  32'(bif.d_req_ready),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit got;
      bit found;
      mem[32'h100] = 32'hDEADBEEF;
      mem[32'h104] = 32'h11110104;
      mem[32'h300] = 32'hCAFEF00D;
      mem[32'h400] = 32'hA0000400;
      mem[32'h404] = 32'hA0000404;
      mem[32'h408] = 32'hA0000408;
      mem[32'h500] = 32'hB0000500;
      mem[32'h504] = 32'hB0000504;
      mem[32'h508] = 32'hB0000508;

      // Requests held high during reset must not be granted.
      bif.if_req_valid     = 1'b1;
      bif.if_req_addr      = 32'h0;
      bif.d_req_valid      = 1'b1;
      bif.d_req_addr       = 32'h0;
      bif.d_req_we         = 1'b0;
      bif.d_req_wdata      = 32'h0;
      bif.d_req_wstrb      = 4'h0;
      bif.invalidate_fetch = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_quiet("reset");
      @(negedge clk);
      bif.if_req_valid = 1'b0;
      bif.d_req_valid  = 1'b0;
      rst = 1'b0;

      // Conflicts out of reset: data, fetch, data, fetch, data, fetch.
      push(1'b1, 32'hB0000500);
      push(1'b0, 32'hA0000400);
      push(1'b1, 32'hB0000504);
      push(1'b0, 32'hA0000404);
      push(1'b1, 32'hB0000508);
      push(1'b0, 32'hA0000408);
      fork
         begin
            do_req(1'b1, 32'h500, 1'b0, 32'h0, 4'h0);
            do_req(1'b1, 32'h504, 1'b0, 32'h0, 4'h0);
            do_req(1'b1, 32'h508, 1'b0, 32'h0, 4'h0);
         end
         begin
            do_req(1'b0, 32'h400, 1'b0, 32'h0, 4'h0);
            do_req(1'b0, 32'h404, 1'b0, 32'h0, 4'h0);
            do_req(1'b0, 32'h408, 1'b0, 32'h0, 4'h0);
         end
      join
      wait_drain();

      // Single fetch with best-case bus timing.
      push(1'b0, 32'hDEADBEEF);
      do_req(1'b0, 32'h100, 1'b0, 32'h0, 4'h0);
      check("fetch_bus_addr",  cap_addr, 32'h100);
      check("fetch_bus_we",    32'(cap_we), 32'd0);
      check("fetch_bus_wstrb", 32'(cap_wstrb), 32'd0);
      wait_drain();
      check("fetch_latency", 32'(rsp_cyc - accept_cyc), 32'd3);

      // Invalidate pulsed while the fetch waits for its response: no pulse.
      rsp_wait = 3;
      do_req(1'b0, 32'h100, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      bif.invalidate_fetch = 1'b1;
      @(negedge clk);
      bif.invalidate_fetch = 1'b0;
      wait_drain();

      // Invalidate coincident with the bus response: no pulse.
      rsp_wait = 2;
      do_req(1'b0, 32'h104, 1'b0, 32'h0, 4'h0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         #1;
         if (bif.bus_rsp_valid) begin
            found = 1'b1;
            bif.invalidate_fetch = 1'b1;
         end
      end
      check("coinc_rsp_seen", 32'(found), 32'd1);
      @(negedge clk);
      bif.invalidate_fetch = 1'b0;
      wait_drain();

      // The next fetch after a drop returns normally.
      rsp_wait = 0;
      push(1'b0, 32'hCAFEF00D);
      do_req(1'b0, 32'h300, 1'b0, 32'h0, 4'h0);
      wait_drain();

      // Data write with the bus request stalled for three cycles.
      stall_n = 3;
      push(1'b1, 32'h0);
      do_req(1'b1, 32'h200, 1'b1, 32'h12345678, 4'hF);
      wait_drain();
      stall_n = 0;
      check("write_bus_addr",  cap_addr, 32'h200);
      check("write_bus_we",    32'(cap_we), 32'd1);
      check("write_bus_wdata", cap_wdata, 32'h12345678);
      check("write_bus_wstrb", 32'(cap_wstrb), 32'hF);

      // Last grant was data, yet an invalidated fetch must lose to the data request.
      @(negedge clk);
      bif.invalidate_fetch = 1'b1;
      bif.if_req_valid     = 1'b1;
      bif.if_req_addr      = 32'h104;
      bif.d_req_valid      = 1'b1;
      bif.d_req_addr       = 32'h504;
      bif.d_req_we         = 1'b0;
      push(1'b1, 32'hB0000504);
      push(1'b0, 32'h11110104);
      #1;
      check("inv_if_ready", 32'(bif.if_req_ready), 32'd0);
      check("inv_d_ready",  32'(bif.d_req_ready),  32'd1);
      @(posedge clk);
      @(negedge clk);
      bif.d_req_valid = 1'b0;
      #1;
      check("busy_if_ready", 32'(bif.if_req_ready), 32'd0);
      @(negedge clk);
      bif.invalidate_fetch = 1'b0;
      wait_grant(1'b0, got);
      @(negedge clk);
      bif.if_req_valid = 1'b0;
      wait_drain();

      // Reset in WAIT_RSP, then a stray bus response: nothing may come out.
      rsp_wait = 4;
      do_req(1'b0, 32'h100, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      model_on = 1'b0;
      #1;
      check_quiet("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      bif.bus_rsp_valid = 1'b1;
      bif.bus_rsp_data  = 32'hBAD0BAD0;
      repeat (3) begin
         @(negedge clk);
         #1;
         check_quiet("stray_rsp");
      end
      bif.bus_rsp_valid = 1'b0;
      model_on = 1'b1;
      rsp_wait = 0;

      push(1'b0, 32'hCAFEF00D);
      do_req(1'b0, 32'h300, 1'b0, 32'h0, 4'h0);
      wait_drain();

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
